// File: rtl/nios2_debug_ocimem_ctrl.sv
// rtl/nios2_debug_ocimem_ctrl.sv - JTAG/CPU debug RAM controller; optional per-byte parity via DEBUG_OCIMEM_PARITY_EN
module nios2_debug_ocimem_ctrl #(
    parameter int unsigned AW       = 8,
    parameter int unsigned RO_WORDS = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_no_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    input  logic          avs_debugaccess,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest
);
`ifdef DEBUG_OCIMEM_PARITY_EN
    localparam int RW = 36;
`else
    localparam int RW = 32;
`endif

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE} state_t;

    state_t        state_q;
    logic [AW-1:0] mon_a_q;
    logic [AW-1:0] mon_a_inc_d;
    logic          auto_inc_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mon_d_q;
    logic          ready_q;
    logic          error_q;
    logic [RW-1:0] ram_rdata_q;
    logic          cpu_rd_valid_q;
    logic [RW-1:0] mem [0:(2**AW)-1];

    logic          pa, pn, pb, any_pulse, multi_pulse;
    logic          fsm_owns, ram_busy, ro_hit, parity_bad;
    logic          cpu_wr_go, cpu_rd_grant;
    logic          ram_we, ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic          unused_jdo;

    assign pa          = take_action_ocimem_a;
    assign pn          = take_no_action_ocimem_a;
    assign pb          = take_action_ocimem_b;
    assign any_pulse   = pa | pn | pb;
    assign multi_pulse = (pa & pn) | (pa & pb) | (pn & pb);
    assign mon_a_inc_d = mon_a_q + 1'b1;
    assign unused_jdo  = ^jdo[35:32];

    // An accepted JTAG pulse reserves the RAM from its own cycle so a CPU
    // access cannot slip in ahead of the issue cycle that follows.
    assign fsm_owns = (state_q == RD_ISSUE) || (state_q == WR_ISSUE);
    assign ram_busy = fsm_owns || ((state_q == IDLE) && any_pulse);

    assign cpu_wr_go       = avs_write & ~ram_busy;
    assign cpu_rd_grant    = avs_read & ~avs_write & ~ram_busy & ~cpu_rd_valid_q;
    assign avs_waitrequest = (avs_write & ram_busy) | (avs_read & ~avs_write & ~cpu_rd_valid_q);
    assign avs_readdata    = ram_rdata_q[31:0];

    generate
        if (RO_WORDS == 0) begin : g_no_ro
            assign ro_hit = 1'b0;
        end else begin : g_ro
            localparam logic [AW:0] RO_LIM = RO_WORDS[AW:0];
            assign ro_hit = ({1'b0, mon_a_q} < RO_LIM);
        end
    endgenerate

    assign ram_addr  = fsm_owns ? mon_a_q : avs_address;
    assign ram_be    = fsm_owns ? 4'hF : avs_byteenable;
    assign ram_wdata = fsm_owns ? wdata_q : avs_writedata;
    assign ram_we    = reset_n & (((state_q == WR_ISSUE) & ~ro_hit) | (cpu_wr_go & avs_debugaccess));
    assign ram_rd_en = (state_q == RD_ISSUE) | cpu_rd_grant;

`ifdef DEBUG_OCIMEM_PARITY_EN
    assign parity_bad = (ram_rdata_q[35:32] != {^ram_rdata_q[31:24], ^ram_rdata_q[23:16],
                                                 ^ram_rdata_q[15:8],  ^ram_rdata_q[7:0]});
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) begin
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
`ifdef DEBUG_OCIMEM_PARITY_EN
                    mem[ram_addr][32+b] <= ^ram_wdata[8*b +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_rdata_q    <= '0;
            cpu_rd_valid_q <= 1'b0;
        end else begin
            if (ram_rd_en) begin
                ram_rdata_q <= mem[ram_addr];
            end
            cpu_rd_valid_q <= cpu_rd_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mon_a_q    <= '0;
            auto_inc_q <= 1'b0;
            wdata_q    <= '0;
            mon_d_q    <= '0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pa) begin
                        mon_a_q    <= jdo[AW-1:0];
                        auto_inc_q <= jdo[36];
                        state_q    <= RD_ISSUE;
                        ready_q    <= 1'b0;
                    end else if (pn) begin
                        if (auto_inc_q) begin
                            mon_a_q <= mon_a_inc_d;
                        end
                        state_q <= RD_ISSUE;
                        ready_q <= 1'b0;
                    end else if (pb) begin
                        wdata_q <= jdo[31:0];
                        state_q <= WR_ISSUE;
                        ready_q <= 1'b0;
                    end
                    // A collision must stay flagged even if the winning pulse asks for a clear.
                    if (multi_pulse) begin
                        error_q <= 1'b1;
                    end else if (pa && jdo[37]) begin
                        error_q <= 1'b0;
                    end
                end
                RD_ISSUE: state_q <= RD_CAPT;
                RD_CAPT: begin
                    mon_d_q <= ram_rdata_q[31:0];
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                    if (parity_bad) begin
                        error_q <= 1'b1;
                    end
                end
                WR_ISSUE: begin
                    if (ro_hit) begin
                        error_q <= 1'b1;
                    end
                    if (auto_inc_q) begin
                        mon_a_q <= mon_a_inc_d;
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if ((state_q != IDLE) && any_pulse) begin
                error_q <= 1'b1;
            end
        end
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// tb/tb_nios2_debug_ocimem_ctrl.sv - scoreboard bench for nios2_debug_ocimem_ctrl
module tb_nios2_debug_ocimem_ctrl;
    localparam int AW = 8;
    localparam int RO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write, avs_debugaccess;
    logic [31:0]   avs_writedata, avs_readdata;
    logic [3:0]    avs_byteenable;
    logic          avs_waitrequest;

    always #5 clk = ~clk;

    nios2_debug_ocimem_ctrl #(.AW(AW), .RO_WORDS(RO)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest)
    );

    typedef struct {logic [31:0] d; logic e; int low;} jexp_t;
    typedef struct {logic [31:0] d; int waits;} cexp_t;
    jexp_t jq[$];
    cexp_t cq[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [256];
    logic [7:0]  m_addr;
    logic        m_auto, m_err;
    logic [31:0] m_dreg;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: got no/unexpected response, expected a matching one", name);
    endtask

    initial begin
        bit prev_ready;
        int low;
        int waits;
        prev_ready = 1'b1;
        low = 0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ready = 1'b1;
                low = 0;
                waits = 0;
            end else begin
                if (!monitor_ready) begin
                    low++;
                end else if (!prev_ready) begin
                    if (jq.size() == 0) begin
                        fail_now("jtag_unexpected");
                    end else begin
                        jexp_t e;
                        e = jq.pop_front();
                        check("mondreg", MonDReg, e.d);
                        check("monitor_error", {31'b0, monitor_error}, {31'b0, e.e});
                        check("jtag_latency", low, e.low);
                    end
                    low = 0;
                end
                prev_ready = monitor_ready;
                if (avs_read && !avs_write) begin
                    if (avs_waitrequest) begin
                        waits++;
                    end else begin
                        if (cq.size() == 0) begin
                            fail_now("cpu_unexpected");
                        end else begin
                            cexp_t c;
                            c = cq.pop_front();
                            check("avs_readdata", avs_readdata, c.d);
                            check("avs_wait_cycles", waits, c.waits);
                        end
                        waits = 0;
                    end
                end
            end
        end
    end

    task automatic pulse(logic a, logic n, logic b, logic [37:0] j);
        @(posedge clk); #1;
        jdo = j;
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b = b;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic wait_ready(string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (monitor_ready) break;
        end
        if (k == 20) fail_now(name);
    endtask

    task automatic jtag_rd_a(logic [7:0] a, logic auto_i, logic clr);
        m_addr = a;
        m_auto = auto_i;
        if (clr) m_err = 1'b0;
        m_dreg = model_mem[m_addr];
        jq.push_back('{m_dreg, m_err, 2});
        pulse(1'b1, 1'b0, 1'b0, {clr, auto_i, 28'($urandom), a});
        wait_ready("timeout_rd_a");
    endtask

    task automatic jtag_next();
        if (m_auto) m_addr = m_addr + 8'd1;
        m_dreg = model_mem[m_addr];
        jq.push_back('{m_dreg, m_err, 2});
        pulse(1'b0, 1'b1, 1'b0, {6'($urandom), 32'($urandom)});
        wait_ready("timeout_next");
    endtask

    task automatic jtag_wr(logic [31:0] d);
        if (m_addr < RO) m_err = 1'b1;
        else model_mem[m_addr] = d;
        if (m_auto) m_addr = m_addr + 8'd1;
        jq.push_back('{m_dreg, m_err, 1});
        pulse(1'b0, 1'b0, 1'b1, {6'($urandom), d});
        wait_ready("timeout_wr");
    endtask

    task automatic cpu_wr(logic [7:0] a, logic [31:0] d, logic [3:0] be, logic dbg);
        int k;
        if (dbg) begin
            for (int b = 0; b < 4; b++) if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_debugaccess = dbg;
        avs_write = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
        end
        if (k == 20) fail_now("timeout_cpu_wr");
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic cpu_rd(logic [7:0] a, int waits);
        int k;
        cq.push_back('{model_mem[a], waits});
        @(posedge clk); #1;
        avs_address = a;
        avs_read = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
        end
        if (k == 20) fail_now("timeout_cpu_rd");
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd1);
        check({tag, "_mondreg"}, MonDReg, 32'd0);
        check({tag, "_error"}, {31'b0, monitor_error}, 32'd0);
        check({tag, "_waitreq"}, {31'b0, avs_waitrequest}, 32'd0);
        check({tag, "_readdata"}, avs_readdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        avs_debugaccess = 1'b0;
        m_addr = '0;
        m_auto = 1'b0;
        m_err = 1'b0;
        m_dreg = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        for (int a = 0; a < 256; a++) cpu_wr(8'(a), $urandom, 4'hF, 1'b1);

        // JTAG write with auto-increment, then a second write lands on the next word
        jtag_rd_a(8'h10, 1'b1, 1'b0);
        jtag_wr(32'hDEADBEEF);
        jtag_wr(32'hCAFEF00D);
        cpu_rd(8'h10, 1);
        cpu_rd(8'h11, 1);

        cpu_wr(8'h20, 32'h12345678, 4'hF, 1'b1);
        jtag_rd_a(8'h20, 1'b0, 1'b0);

        jtag_rd_a(8'hFF, 1'b1, 1'b0);
        jtag_next();

        // overrun: no_action pulse arrives while the read is in RD_ISSUE
        m_addr = 8'h33;
        m_auto = 1'b0;
        m_dreg = model_mem[m_addr];
        m_err = 1'b1;
        jq.push_back('{m_dreg, m_err, 2});
        @(posedge clk); #1;
        jdo = {2'b00, 28'h0, 8'h33};
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        wait_ready("timeout_overrun");

        jtag_rd_a(8'h34, 1'b0, 1'b1);
        // collision: read wins, write dropped, error set
        m_addr = 8'h34;
        m_auto = 1'b0;
        m_dreg = model_mem[m_addr];
        m_err = 1'b1;
        jq.push_back('{m_dreg, m_err, 2});
        pulse(1'b1, 1'b0, 1'b1, {2'b00, 28'h5A5A5A5, 8'h34});
        wait_ready("timeout_collision");
        cpu_rd(8'h34, 1);
        jtag_rd_a(8'h35, 1'b0, 1'b1);

        fork
            jtag_rd_a(8'h05, 1'b0, 1'b0);
            cpu_rd(8'h05, 3);
        join

        cpu_wr(8'h30, 32'hA1B2C3D4, 4'b0010, 1'b1);
        cpu_rd(8'h30, 1);
        cpu_wr(8'h30, 32'h11223344, 4'b0010, 1'b0);
        cpu_rd(8'h30, 1);

        jtag_rd_a(8'h02, 1'b0, 1'b1);
        jtag_wr(32'h0BADF00D);
        cpu_rd(8'h02, 1);
        jtag_rd_a(8'h02, 1'b0, 1'b1);

`ifdef DEBUG_OCIMEM_PARITY_EN
        cpu_wr(8'h40, 32'h0F0F00FF, 4'hF, 1'b1);
        dut.mem[64][32] = ~dut.mem[64][32];
        m_addr = 8'h40;
        m_auto = 1'b0;
        m_dreg = model_mem[m_addr];
        m_err = 1'b1;
        jq.push_back('{m_dreg, m_err, 2});
        pulse(1'b1, 1'b0, 1'b0, {2'b10, 28'h0, 8'h40});
        wait_ready("timeout_parity");
`endif

        // reset while the write sits in WR_ISSUE must not commit it
        jtag_rd_a(8'h50, 1'b0, 1'b0);
        @(posedge clk); #1;
        jdo = {6'b0, 32'h55AA55AA};
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_addr = '0;
        m_auto = 1'b0;
        m_err = 1'b0;
        m_dreg = '0;
        @(negedge clk);
        check_reset_state("midop_reset");
        cpu_rd(8'h50, 1);
        jtag_rd_a(8'h50, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: jtag_rd_a(8'($urandom), 1'($urandom), 1'($urandom));
                1: jtag_next();
                2: jtag_wr($urandom);
                3: cpu_rd(8'($urandom), 1);
                default: cpu_wr(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
            endcase
        end

        repeat (5) @(posedge clk);
        check("jtag_queue_drained", jq.size(), 32'd0);
        check("cpu_queue_drained", cq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
